dmem_arbiter: RTL and testbench

Shares the single-port data memory of the MIPS core between two requesters: requester 0 is the core load/store path and requester 1 is the program/data loader port.
- Serialises accesses with round-robin priority.
- Holds address and control stable to memory for a fixed latency, then returns read data with a one-cycle done pulse.
- Sits between the datapath memory stage and the data memory array.

---
 rtl/mips_mem_pkg.sv | 32 +++
 rtl/rr_arb2.sv | 28 ++
 rtl/dmem_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MIPS data-memory subsystem.
//   arb_state_t : arbiter FSM states (IDLE, ACCESS, DONE)
//   req_id_t    : requester index (0 = core load/store, 1 = loader port)
//   WORD_W      : data word width
//   DMEM_AW     : data memory word-address width
//   rr_pick     : two-way round-robin selection helper
package mips_mem_pkg;

  localparam int WORD_W  = 32;
  localparam int DMEM_AW = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_t;

  typedef logic req_id_t;

  // On a tie the requester that was not granted last time wins.
  function automatic req_id_t rr_pick(input logic [1:0] req, input req_id_t last);
    req_id_t pick;
    case (req)
      2'b01:   pick = 1'b0;
      2'b10:   pick = 1'b1;
      2'b11:   pick = ~last;
      default: pick = 1'b0;
    endcase
    return pick;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin picker.
//   req[1:0]    : request vector (bit N = requester N)
//   last        : index of the requester granted most recently
//   grant_valid : at least one request is present
//   grant_id    : index of the winning requester
module rr_arb2
  import mips_mem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant_valid,
  output logic       grant_id
);

  // Winner selection; grant_id is only meaningful while grant_valid is high.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    if (req != 2'b00) begin
      grant_valid = 1'b1;
      grant_id    = rr_pick(req, last);
    end else begin
      grant_valid = 1'b0;
      grant_id    = 1'b0;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the core
// load/store path (r0) and the loader port (r1).
//   clk, rst           : clock; asynchronous active-low reset
//   rN_req/we/addr/wdata : requester N access request (held until rN_gnt)
//   rN_gnt             : one-cycle grant pulse (first access cycle)
//   rN_done, rN_rdata  : one-cycle completion pulse; read data for reads
//   mem_en/we/addr/wdata, mem_rdata : memory array interface
//   busy               : high whenever the FSM is not IDLE
// Every access takes MEM_LAT cycles with address/control held stable, then
// one DONE cycle; mem_rdata is captured in the last access cycle.
module dmem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int AW      = DMEM_AW,
  parameter int DW      = WORD_W,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_gnt,
  output logic          r0_done,
  output logic [DW-1:0] r0_rdata,
  input  logic          r1_req,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_gnt,
  output logic          r1_done,
  output logic [DW-1:0] r1_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LAT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  arb_state_t    state_r, next_state_s;
  logic [CW-1:0] cnt_r;
  req_id_t       owner_r;
  req_id_t       last_r;
  logic          we_r;
  logic [AW-1:0] addr_r;
  logic [DW-1:0] wdata_r;
  logic          gnt0_r, gnt1_r, done0_r, done1_r;
  logic [DW-1:0] rdata0_r, rdata1_r;
  logic          mem_en_r, mem_we_r, busy_r;

  logic          grant_valid_s;
  req_id_t       grant_id_s;
  logic          start_s, finish_s;
  logic          sel_we_s;
  logic [AW-1:0] sel_addr_s;
  logic [DW-1:0] sel_wdata_s;

  rr_arb2 u_rr_arb2 (
    .req         ({r1_req, r0_req}),
    .last        (last_r),
    .grant_valid (grant_valid_s),
    .grant_id    (grant_id_s)
  );

  // Next-state logic plus start/finish strobes and the winner's request mux.
  always_comb begin
    next_state_s = state_r;
    start_s      = 1'b0;
    finish_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (grant_valid_s) begin
          next_state_s = ACCESS;
          start_s      = 1'b1;
        end else begin
          next_state_s = IDLE;
        end
      end
      ACCESS: begin
        if (cnt_r == CNT_ZERO) begin
          next_state_s = DONE;
          finish_s     = 1'b1;
        end else begin
          next_state_s = ACCESS;
        end
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase

    if (grant_id_s == 1'b1) begin
      sel_we_s    = r1_we;
      sel_addr_s  = r1_addr;
      sel_wdata_s = r1_wdata;
    end else begin
      sel_we_s    = r0_we;
      sel_addr_s  = r0_addr;
      sel_wdata_s = r0_wdata;
    end
  end

  // FSM state, latency counter and round-robin pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      last_r  <= 1'b1;
    end else begin
      state_r <= next_state_s;
      if (start_s) begin
        cnt_r  <= CNT_LOAD;
        last_r <= grant_id_s;
      end else if (state_r == ACCESS && cnt_r != CNT_ZERO) begin
        cnt_r  <= cnt_r - CNT_ONE;
        last_r <= last_r;
      end else begin
        cnt_r  <= cnt_r;
        last_r <= last_r;
      end
    end
  end

  // Access latch: winner's request is frozen at grant so later input changes
  // cannot disturb the access in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_r <= 1'b0;
      we_r    <= 1'b0;
      addr_r  <= {AW{1'b0}};
      wdata_r <= {DW{1'b0}};
    end else if (start_s) begin
      owner_r <= grant_id_s;
      we_r    <= sel_we_s;
      addr_r  <= sel_addr_s;
      wdata_r <= sel_wdata_s;
    end else begin
      owner_r <= owner_r;
      we_r    <= we_r;
      addr_r  <= addr_r;
      wdata_r <= wdata_r;
    end
  end

  // Registered handshake and memory-enable outputs, derived from the next state
  // so they line up with the state they belong to.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt0_r   <= 1'b0;
      gnt1_r   <= 1'b0;
      done0_r  <= 1'b0;
      done1_r  <= 1'b0;
      mem_en_r <= 1'b0;
      mem_we_r <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      gnt0_r   <= start_s && (grant_id_s == 1'b0);
      gnt1_r   <= start_s && (grant_id_s == 1'b1);
      done0_r  <= finish_s && (owner_r == 1'b0);
      done1_r  <= finish_s && (owner_r == 1'b1);
      mem_en_r <= (next_state_s == ACCESS);
      if (start_s) begin
        mem_we_r <= sel_we_s;
      end else if (next_state_s == ACCESS) begin
        mem_we_r <= we_r;
      end else begin
        mem_we_r <= 1'b0;
      end
      busy_r   <= (next_state_s != IDLE);
    end
  end

  // Read data capture on the edge leaving ACCESS; writes leave rdata untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata0_r <= {DW{1'b0}};
      rdata1_r <= {DW{1'b0}};
    end else if (finish_s && !we_r) begin
      if (owner_r == 1'b1) begin
        rdata0_r <= rdata0_r;
        rdata1_r <= mem_rdata;
      end else begin
        rdata0_r <= mem_rdata;
        rdata1_r <= rdata1_r;
      end
    end else begin
      rdata0_r <= rdata0_r;
      rdata1_r <= rdata1_r;
    end
  end

  assign r0_gnt    = gnt0_r;
  assign r1_gnt    = gnt1_r;
  assign r0_done   = done0_r;
  assign r1_done   = done1_r;
  assign r0_rdata  = rdata0_r;
  assign r1_rdata  = rdata1_r;
  assign mem_en    = mem_en_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = addr_r;
  assign mem_wdata = wdata_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter: one instance with MEM_LAT=1
// and one with MEM_LAT=3 share requester inputs; use3 routes requests to one.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        use3 = 1'b0;
  logic        r0_req = 1'b0, r0_we = 1'b0, r1_req = 1'b0, r1_we = 1'b0;
  logic [9:0]  r0_addr = 10'd0, r1_addr = 10'd0;
  logic [31:0] r0_wdata = 32'd0, r1_wdata = 32'd0;
  logic [31:0] rd_data1 = 32'd0, rd_data3 = 32'd0;

  logic        d1_r0_gnt, d1_r0_done, d1_r1_gnt, d1_r1_done;
  logic [31:0] d1_r0_rdata, d1_r1_rdata, d1_mem_wdata;
  logic        d1_mem_en, d1_mem_we, d1_busy;
  logic [9:0]  d1_mem_addr;
  logic        d3_r0_gnt, d3_r0_done, d3_r1_gnt, d3_r1_done;
  logic [31:0] d3_r0_rdata, d3_r1_rdata, d3_mem_wdata;
  logic        d3_mem_en, d3_mem_we, d3_busy;
  logic [9:0]  d3_mem_addr;

  logic [9:0]  wa1 = 10'd0, wa3 = 10'd0;
  logic [31:0] wd1 = 32'd0, wd3 = 32'd0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(10), .DW(32), .MEM_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .r0_req(r0_req & ~use3), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(d1_r0_gnt), .r0_done(d1_r0_done), .r0_rdata(d1_r0_rdata),
    .r1_req(r1_req & ~use3), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(d1_r1_gnt), .r1_done(d1_r1_done), .r1_rdata(d1_r1_rdata),
    .mem_en(d1_mem_en), .mem_we(d1_mem_we), .mem_addr(d1_mem_addr),
    .mem_wdata(d1_mem_wdata), .mem_rdata(rd_data1), .busy(d1_busy)
  );

  dmem_arbiter #(.AW(10), .DW(32), .MEM_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .r0_req(r0_req & use3), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(d3_r0_gnt), .r0_done(d3_r0_done), .r0_rdata(d3_r0_rdata),
    .r1_req(r1_req & use3), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(d3_r1_gnt), .r1_done(d3_r1_done), .r1_rdata(d3_r1_rdata),
    .mem_en(d3_mem_en), .mem_we(d3_mem_we), .mem_addr(d3_mem_addr),
    .mem_wdata(d3_mem_wdata), .mem_rdata(rd_data3), .busy(d3_busy)
  );

  // Memory write model: remembers the last written address/data per instance.
  always @(posedge clk) begin
    if (d1_mem_en && d1_mem_we) begin
      wa1 <= d1_mem_addr;
      wd1 <= d1_mem_wdata;
    end
    if (d3_mem_en && d3_mem_we) begin
      wa3 <= d3_mem_addr;
      wd3 <= d3_mem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    r0_req = 1'b0; r0_we = 1'b0; r0_addr = 10'd0; r0_wdata = 32'd0;
    r1_req = 1'b0; r1_we = 1'b0; r1_addr = 10'd0; r1_wdata = 32'd0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    do_reset();
    // Reset state
    chk("rst_busy", {31'd0, d1_busy}, 32'd0);
    chk("rst_mem_en", {31'd0, d1_mem_en}, 32'd0);
    chk("rst_r0_rdata", d1_r0_rdata, 32'd0);
    chk("rst_gnt", {30'd0, d1_r1_gnt, d1_r0_gnt}, 32'd0);

    // Single read, MEM_LAT=1
    rd_data1 = 32'h1234_5678;
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 10'h005;
    step();
    chk("t1_r0_gnt", {31'd0, d1_r0_gnt}, 32'd1);
    chk("t1_mem_en", {31'd0, d1_mem_en}, 32'd1);
    chk("t1_mem_addr", {22'd0, d1_mem_addr}, 32'h005);
    chk("t1_r1_gnt", {31'd0, d1_r1_gnt}, 32'd0);
    r0_req = 1'b0;
    step();
    chk("t1_r0_done", {31'd0, d1_r0_done}, 32'd1);
    chk("t1_r0_rdata", d1_r0_rdata, 32'h1234_5678);
    chk("t1_mem_en_off", {31'd0, d1_mem_en}, 32'd0);
    chk("t1_r1_quiet", {d1_r1_rdata[29:0], d1_r1_gnt, d1_r1_done}, 32'd0);
    step();
    chk("t1_idle", {31'd0, d1_busy}, 32'd0);

    // Simultaneous requests after reset: r0 write wins, then r1 read
    do_reset();
    rd_data1 = 32'h5555_1111;
    r0_req = 1'b1; r0_we = 1'b1; r0_addr = 10'h010; r0_wdata = 32'hAAAA_0000;
    r1_req = 1'b1; r1_we = 1'b0; r1_addr = 10'h011;
    step();
    chk("t2_gnt_t1", {30'd0, d1_r1_gnt, d1_r0_gnt}, 32'b01);
    chk("t2_mem_we", {31'd0, d1_mem_we}, 32'd1);
    r0_req = 1'b0;
    step();
    chk("t2_done_t2", {30'd0, d1_r1_done, d1_r0_done}, 32'b01);
    chk("t2_wr_addr", {22'd0, wa1}, 32'h010);
    chk("t2_wr_data", wd1, 32'hAAAA_0000);
    step();
    chk("t2_idle_t3", {30'd0, d1_r1_gnt, d1_busy}, 32'd0);
    step();
    chk("t2_gnt_t4", {30'd0, d1_r1_gnt, d1_r0_gnt}, 32'b10);
    chk("t2_addr_t4", {22'd0, d1_mem_addr}, 32'h011);
    r1_req = 1'b0;
    step();
    chk("t2_done_t5", {30'd0, d1_r1_done, d1_r0_done}, 32'b10);
    chk("t2_r1_rdata", d1_r1_rdata, 32'h5555_1111);
    chk("t2_r0_rdata_kept", d1_r0_rdata, 32'd0);
    step();

    // Fairness: both held for four transactions
    r0_req = 1'b1; r0_we = 1'b0; r1_req = 1'b1; r1_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("fair_gnt%0d", i), {30'd0, d1_r1_gnt, d1_r0_gnt},
          (i % 2 == 0) ? 32'b01 : 32'b10);
      step();
      chk($sformatf("fair_done%0d", i), {30'd0, d1_r1_done, d1_r0_done},
          (i % 2 == 0) ? 32'b01 : 32'b10);
      if (i == 3) begin
        r0_req = 1'b0; r1_req = 1'b0;
      end
      step();
      chk($sformatf("fair_idle%0d", i), {29'd0, d1_busy, d1_r1_gnt, d1_r0_gnt}, 32'd0);
    end

    // MEM_LAT=3 read by r1; data changes after first access cycle
    use3 = 1'b1;
    rd_data3 = 32'h0BAD_F00D;
    r1_req = 1'b1; r1_we = 1'b0; r1_addr = 10'h3FF;
    step();
    chk("t4_c1", {d3_mem_addr, 19'd0, d3_r1_gnt, d3_mem_en, d3_mem_we}, {10'h3FF, 19'd0, 3'b110});
    r1_req = 1'b0;
    step();
    chk("t4_c2", {d3_mem_addr, 19'd0, d3_r1_gnt, d3_mem_en, d3_mem_we}, {10'h3FF, 19'd0, 3'b010});
    rd_data3 = 32'hC0DE_1234;
    step();
    chk("t4_c3", {d3_mem_addr, 19'd0, d3_r1_done, d3_mem_en, d3_mem_we}, {10'h3FF, 19'd0, 3'b010});
    step();
    chk("t4_done", {29'd0, d3_r1_done, d3_mem_en, d3_r0_done}, 32'b100);
    chk("t4_rdata", d3_r1_rdata, 32'hC0DE_1234);
    step();

    // Stability: r0 inputs change during ACCESS
    r0_req = 1'b1; r0_we = 1'b1; r0_addr = 10'h020; r0_wdata = 32'h1111_2222;
    step();
    chk("t5_gnt", {31'd0, d3_r0_gnt}, 32'd1);
    r0_req = 1'b0; r0_addr = 10'h021; r0_wdata = 32'h9999_9999;
    step();
    chk("t5_addr_c2", {22'd0, d3_mem_addr}, 32'h020);
    chk("t5_wdata_c2", d3_mem_wdata, 32'h1111_2222);
    step();
    chk("t5_addr_c3", {22'd0, d3_mem_addr}, 32'h020);
    step();
    chk("t5_done", {31'd0, d3_r0_done}, 32'd1);
    chk("t5_wr_addr", {22'd0, wa3}, 32'h020);
    chk("t5_wr_data", wd3, 32'h1111_2222);
    step();

    // Reset in the second access cycle, then tie goes to r0
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 10'h030;
    step();
    chk("t6_gnt", {31'd0, d3_r0_gnt}, 32'd1);
    r0_req = 1'b0;
    step();
    rst = 1'b0;
    #1;
    chk("t6_async", {28'd0, d3_mem_en, d3_busy, d3_r0_gnt, d3_r0_done}, 32'd0);
    step();
    chk("t6_hold", {29'd0, d3_mem_en, d3_r0_done, d3_r1_done}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    chk("t6_post_idle", {31'd0, d3_busy}, 32'd0);
    r0_req = 1'b1; r1_req = 1'b1; r1_we = 1'b0;
    step();
    chk("t6_tie", {30'd0, d3_r1_gnt, d3_r0_gnt}, 32'b01);
    clear_inputs();
    repeat (6) step();
    chk("t6_no_spurious", {30'd0, d3_busy, d3_r1_gnt}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
